// File: rtl/psram_uart_cmd.sv
// psram_uart_cmd
// Command sequencer between a UART byte receiver/transmitter and the PSRAM
// controller. Byte frames from the receiver are parsed into single 16-bit
// PSRAM transactions, and a response is returned to the transmitter.
//
// Frame:  'W' (0x57) A2 A1 A0 D1 D0   -> write, response 'K' (0x4B)
//         'R' (0x52) A2 A1 A0         -> read,  response rdata[15:8], rdata[7:0]
//         any other opcode byte       -> response '?' (0x3F)
//         PSRAM hang (no endcommand)  -> response 'E' (0x45), err set (sticky)
// Bit 7 of A2 is dropped, giving a 23-bit word address.
//
// Ports:
//   mem_clk, rst          clock (posedge) and synchronous active-high reset
//   rx_data, rx_valid     received byte and its one-cycle strobe
//   tx_data, tx_valid     byte to transmit, held until tx_ready accepts it
//   tx_ready              transmitter handshake
//   qpi_on                PSRAM initialised; transactions wait for it
//   endcommand            PSRAM transaction finished (level, high when idle)
//   psram_rdata           PSRAM read data
//   address, read_write   transaction address / kind (0 none, 1 write, 2 read)
//   quad_start            one-cycle transaction start pulse
//   data_in               write data
//   busy                  high whenever not idle
//   err                   sticky PSRAM timeout flag
module psram_uart_cmd #(
  parameter int DONE_TIMEOUT = 64,
  parameter int RX_TIMEOUT   = 65535
) (
  input  logic        mem_clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        qpi_on,
  input  logic        endcommand,
  input  logic [15:0] psram_rdata,
  output logic [22:0] address,
  output logic [1:0]  read_write,
  output logic        quad_start,
  output logic [15:0] data_in,
  output logic        busy,
  output logic        err
);

  localparam int RXT_W = $clog2(RX_TIMEOUT + 1);
  localparam int DNT_W = $clog2(DONE_TIMEOUT + 1);

  localparam logic [7:0] OP_W    = 8'h57;
  localparam logic [7:0] OP_R    = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_BAD = 8'h3F;
  localparam logic [7:0] RSP_ERR = 8'h45;

  localparam logic [1:0] RW_NONE  = 2'd0;
  localparam logic [1:0] RW_WRITE = 2'd1;
  localparam logic [1:0] RW_READ  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t             state, state_nxt;
  logic               op_rd, op_rd_nxt;
  logic [1:0]         byte_cnt, byte_cnt_nxt;
  logic [RXT_W-1:0]   rx_tmr, rx_tmr_nxt;
  logic [DNT_W-1:0]   done_tmr, done_tmr_nxt;
  logic [7:0]         rd_lo, rd_lo_nxt;
  logic               resp_more, resp_more_nxt;
  logic [22:0]        address_nxt;
  logic [1:0]         read_write_nxt;
  logic               quad_start_nxt;
  logic [15:0]        data_in_nxt;
  logic [7:0]         tx_data_nxt;
  logic               tx_valid_nxt;
  logic               err_nxt;

  assign busy = (state != S_IDLE);

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_rd      <= 1'b0;
      byte_cnt   <= '0;
      rx_tmr     <= '0;
      done_tmr   <= '0;
      rd_lo      <= '0;
      resp_more  <= 1'b0;
      address    <= '0;
      read_write <= RW_NONE;
      quad_start <= 1'b0;
      data_in    <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      op_rd      <= op_rd_nxt;
      byte_cnt   <= byte_cnt_nxt;
      rx_tmr     <= rx_tmr_nxt;
      done_tmr   <= done_tmr_nxt;
      rd_lo      <= rd_lo_nxt;
      resp_more  <= resp_more_nxt;
      address    <= address_nxt;
      read_write <= read_write_nxt;
      quad_start <= quad_start_nxt;
      data_in    <= data_in_nxt;
      tx_data    <= tx_data_nxt;
      tx_valid   <= tx_valid_nxt;
      err        <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    op_rd_nxt      = op_rd;
    byte_cnt_nxt   = byte_cnt;
    rx_tmr_nxt     = '0;
    done_tmr_nxt   = '0;
    rd_lo_nxt      = rd_lo;
    resp_more_nxt  = resp_more;
    address_nxt    = address;
    read_write_nxt = read_write;
    quad_start_nxt = 1'b0;
    data_in_nxt    = data_in;
    tx_data_nxt    = tx_data;
    tx_valid_nxt   = tx_valid;
    err_nxt        = err;

    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == OP_W || rx_data == OP_R) begin
            op_rd_nxt    = (rx_data == OP_R);
            byte_cnt_nxt = '0;
            state_nxt    = S_GET_ADDR;
          end else begin
            tx_data_nxt   = RSP_BAD;
            tx_valid_nxt  = 1'b1;
            resp_more_nxt = 1'b0;
            state_nxt     = S_RESP;
          end
        end
      end

      // The address shifts in MSB first; after 24 bits the unused top bit of
      // the first byte has been pushed out of the 23-bit register.
      S_GET_ADDR: begin
        rx_tmr_nxt = rx_tmr + RXT_W'(1);
        if (rx_valid) begin
          rx_tmr_nxt   = '0;
          address_nxt  = {address[14:0], rx_data};
          byte_cnt_nxt = byte_cnt + 2'd1;
          if (byte_cnt == 2'd2) begin
            byte_cnt_nxt = '0;
            if (!op_rd) begin
              state_nxt = S_GET_DATA;
            end else if (qpi_on) begin
              // Launch straight from the last byte so quad_start lands on
              // the very next cycle, together with the updated address.
              read_write_nxt = RW_READ;
              quad_start_nxt = 1'b1;
              state_nxt      = S_WAIT_LOW;
            end else begin
              state_nxt = S_ISSUE;
            end
          end
        end else if (rx_tmr >= RXT_W'(RX_TIMEOUT - 1)) begin
          state_nxt = S_IDLE;
        end
      end

      S_GET_DATA: begin
        rx_tmr_nxt = rx_tmr + RXT_W'(1);
        if (rx_valid) begin
          rx_tmr_nxt   = '0;
          data_in_nxt  = {data_in[7:0], rx_data};
          byte_cnt_nxt = byte_cnt + 2'd1;
          if (byte_cnt == 2'd1) begin
            byte_cnt_nxt = '0;
            if (qpi_on) begin
              read_write_nxt = RW_WRITE;
              quad_start_nxt = 1'b1;
              state_nxt      = S_WAIT_LOW;
            end else begin
              state_nxt = S_ISSUE;
            end
          end
        end else if (rx_tmr >= RXT_W'(RX_TIMEOUT - 1)) begin
          state_nxt = S_IDLE;
        end
      end

      S_ISSUE: begin
        if (qpi_on) begin
          read_write_nxt = op_rd ? RW_READ : RW_WRITE;
          quad_start_nxt = 1'b1;
          state_nxt      = S_WAIT_LOW;
        end
      end

      // endcommand idles high, so the transaction is only considered running
      // once it has been seen low.
      S_WAIT_LOW: begin
        done_tmr_nxt = done_tmr + DNT_W'(1);
        if (done_tmr >= DNT_W'(DONE_TIMEOUT - 1)) begin
          err_nxt        = 1'b1;
          read_write_nxt = RW_NONE;
          tx_data_nxt    = RSP_ERR;
          tx_valid_nxt   = 1'b1;
          resp_more_nxt  = 1'b0;
          state_nxt      = S_RESP;
        end else if (!endcommand) begin
          state_nxt = S_WAIT_DONE;
        end
      end

      // Completion has priority over a timeout expiring in the same cycle.
      S_WAIT_DONE: begin
        done_tmr_nxt = done_tmr + DNT_W'(1);
        if (endcommand) begin
          read_write_nxt = RW_NONE;
          tx_valid_nxt   = 1'b1;
          if (op_rd) begin
            tx_data_nxt   = psram_rdata[15:8];
            rd_lo_nxt     = psram_rdata[7:0];
            resp_more_nxt = 1'b1;
          end else begin
            tx_data_nxt   = RSP_OK;
            resp_more_nxt = 1'b0;
          end
          state_nxt = S_RESP;
        end else if (done_tmr >= DNT_W'(DONE_TIMEOUT - 1)) begin
          err_nxt        = 1'b1;
          read_write_nxt = RW_NONE;
          tx_data_nxt    = RSP_ERR;
          tx_valid_nxt   = 1'b1;
          resp_more_nxt  = 1'b0;
          state_nxt      = S_RESP;
        end
      end

      S_RESP: begin
        if (tx_valid && tx_ready) begin
          if (resp_more) begin
            tx_data_nxt   = rd_lo;
            resp_more_nxt = 1'b0;
          end else begin
            tx_valid_nxt = 1'b0;
            state_nxt    = S_IDLE;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/psram_uart_cmd.md
Name: psram_uart_cmd

Overview:
- Command sequencer between the UART byte receiver/transmitter and the `psram` top module.
- Parses byte frames from UART RX into single 16-bit PSRAM read/write transactions.
- Drives `quad_start`/`address`/`read_write`/`data_in` and waits for `endcommand`.
- Returns an ack byte (write) or two read-data bytes (read) to UART TX.

Parameters:
- `DONE_TIMEOUT`, 64, max `mem_clk` cycles in the wait states before declaring the PSRAM hung.
- `RX_TIMEOUT`, 65535, max `mem_clk` cycles between frame bytes before a partial frame is discarded.

Ports:
- `mem_clk`  in  1  system/PSRAM clock; all logic on posedge.
- `rst`  in  1  synchronous active-high reset.
- `rx_data`  in  8  received UART byte.
- `rx_valid`  in  1  one-cycle strobe, `rx_data` valid.
- `tx_data`  out  8  byte to transmit.
- `tx_valid`  out  1  `tx_data` valid; held until accepted.
- `tx_ready`  in  1  transmitter accepts on `tx_valid && tx_ready`.
- `qpi_on`  in  1  PSRAM init complete (QPI mode).
- `endcommand`  in  1  PSRAM transaction finished (level).
- `psram_rdata`  in  16  PSRAM `data_out`.
- `address`  out  23  PSRAM word address.
- `read_write`  out  2  0 = none, 1 = write, 2 = read.
- `quad_start`  out  1  one-cycle transaction start pulse.
- `data_in`  out  16  PSRAM write data.
- `busy`  out  1  high in any state but IDLE.
- `err`  out  1  sticky; set on PSRAM timeout; cleared by `rst` only.

Behaviour:
- Reset (synchronous, `rst`=1 at posedge):
  - State → IDLE.
  - `address`=0, `read_write`=0, `quad_start`=0, `data_in`=0.
  - `tx_valid`=0, `tx_data`=0, `busy`=0, `err`=0.
  - All counters cleared. Reset mid-operation abandons the transaction and any pending TX byte.
- Frame format:
  - Opcode: 0x57 'W' or 0x52 'R'.
  - 3 address bytes, MSB first; bit 7 of the first address byte is ignored → 23-bit address.
  - 'W' only: 2 data bytes, MSB first.
- States:
  - IDLE:
    - 'W' or 'R' on `rx_valid` → latch op, go GET_ADDR.
    - Any other byte → TX 0x3F ('?') via RESP.
  - GET_ADDR: shift in 3 bytes. After the 3rd: 'W' → GET_DATA, 'R' → ISSUE.
  - GET_DATA: shift in 2 bytes into `data_in`, then ISSUE.
  - ISSUE:
    - Waits while `qpi_on`=0; frame is held, never dropped.
    - When `qpi_on`=1: drive `read_write` (1 or 2), assert `quad_start` for exactly one cycle, go WAIT_LOW.
  - WAIT_LOW:
    - `endcommand` stays high between transactions, so a stale high is ignored.
    - Wait for `endcommand`=0, then WAIT_DONE.
  - WAIT_DONE:
    - On `endcommand`=1: capture `psram_rdata` (reads), set `read_write`=0, go RESP.
    - Write response: one byte 0x4B ('K').
    - Read response: two bytes, `psram_rdata[15:8]` then `[7:0]`.
  - RESP:
    - Present each byte with `tx_valid`=1.
    - Byte advances only on `tx_valid && tx_ready`; `tx_data` is stable while waiting.
    - After the last byte is accepted → IDLE, `tx_valid`=0.
- Stability: `address`, `data_in` and `read_write` hold constant from the `quad_start` cycle through `endcommand`; the PSRAM driver samples them across the whole transaction.
- Earliest `quad_start`: the cycle after the final frame byte's `rx_valid`, when `qpi_on`=1.
- PSRAM timeout:
  - The cycle counter starts at `quad_start`.
  - Reaching `DONE_TIMEOUT` in WAIT_LOW or WAIT_DONE: set `err`, `read_write`=0, TX 0x45 ('E'), go IDLE.
- RX inter-byte timeout:
  - Applies in GET_ADDR and GET_DATA.
  - `RX_TIMEOUT` cycles with no `rx_valid` → silently return to IDLE and discard the partial frame.
- `rx_valid` during ISSUE, WAIT_LOW, WAIT_DONE or RESP: byte dropped, no state effect.
- Simultaneous `rx_valid` and a timeout expiry in GET_*: the byte wins and the timer restarts.

Test Plan:
- `qpi_on`=1; RX 57 00 12 34 AB CD → one-cycle `quad_start`, `address`=0x001234, `read_write`=1, `data_in`=0xABCD; `endcommand` low then high → TX 0x4B; `read_write` returns 0.
- RX 52 80 00 10 with `psram_rdata`=0xBEEF at `endcommand` rise → `address`=0x000010 (MSB ignored), `read_write`=2; TX 0xBE then 0xEF.
- `qpi_on`=0 during the full 'R' frame → no `quad_start` until `qpi_on` rises; then exactly one pulse.
- RX 0x41 → TX 0x3F, back to IDLE; following valid frame processes normally.
- `endcommand` never falls after `quad_start` → after 64 cycles `err`=1, TX 0x45, IDLE.
- `tx_ready`=0 for 10 cycles during a read response → 0xBE held stable, no loss; `rst` mid-WAIT_DONE → all outputs reset, next frame runs clean.
